// File: rtl/nw_vc_free_pool_if.sv
// Free-VC pool interface: allocator/credit side drives frees and pops,
// the pool returns per-port head ids, free bitmap, occupancy and error flags.
interface nw_vc_free_pool_if #(
  parameter int np = 5,
  parameter int nv = 4,
  parameter int cw = $clog2(nv + 1)
) ();
  logic [np-1:0][nv-1:0] vc_freed;
  logic [np-1:0]         pop_free_vc;
  logic [np-1:0][nv-1:0] next_free_vc;
  logic [np-1:0]         no_free_vc;
  logic [np-1:0][nv-1:0] vc_alloc_status;
  logic [np-1:0][cw-1:0] free_count;
  logic [np-1:0]         pool_error;

  modport master (
    output vc_freed, pop_free_vc,
    input  next_free_vc, no_free_vc, vc_alloc_status, free_count, pool_error
  );
  modport slave (
    input  vc_freed, pop_free_vc,
    output next_free_vc, no_free_vc, vc_alloc_status, free_count, pool_error
  );
endinterface

// File: rtl/nw_vc_free_pool.sv
// Per-output-port FIFO of free VC ids for the restricted VC allocator, plus
// a free bitmap; one independent pool instance per router port.
module nw_vc_free_pool_port #(
  parameter int nv = 4,
  parameter int cw = $clog2(nv + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [nv-1:0] vc_freed,
  input  logic          pop,
  output logic [nv-1:0] next_free_vc,
  output logic          no_free_vc,
  output logic [nv-1:0] status,
  output logic [cw-1:0] count,
  output logic          err
);
  localparam int lw = $clog2(nv);
  localparam logic [cw-1:0] FULL = cw'(nv);

  logic [nv-1:0][lw-1:0] mem;
  logic [lw-1:0]         rd_ptr, wr_ptr, push_idx;
  logic [nv-1:0]         head_oh, status_nxt;
  logic                  empty, full, pop_ok, any, multi, dup, push_ok, err_now;

  assign empty = (count == '0);
  assign full  = (count == FULL);

  always_comb begin
    head_oh = '0;
    head_oh[mem[rd_ptr]] = 1'b1;
  end

  always_comb begin
    push_idx = '0;
    for (int i = 0; i < nv; i++)
      if (vc_freed[i]) push_idx = lw'(i);
  end

  assign pop_ok  = pop && !empty;
  assign any     = |vc_freed;
  assign multi   = |(vc_freed & (vc_freed - 1'b1));
  // The VC leaving the head this cycle may legally come straight back.
  assign dup     = |(vc_freed & status) && !(pop_ok && vc_freed == head_oh);
  assign push_ok = any && !multi && !dup && !(full && !pop_ok);
  assign err_now = (pop && empty) || multi || (any && !multi && !push_ok);

  always_comb begin
    status_nxt = status;
    if (pop_ok)  status_nxt = status_nxt & ~head_oh;
    if (push_ok) status_nxt = status_nxt | vc_freed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < nv; i++) mem[i] <= lw'(i);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= FULL;
      status <= '1;
      err    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      status <= status_nxt;
      if (err_now) err <= 1'b1;
    end
  end

  assign no_free_vc   = empty;
  assign next_free_vc = empty ? '0 : head_oh;
endmodule

module nw_vc_free_pool #(
  parameter int np = 5,
  parameter int nv = 4,
  parameter int cw = $clog2(nv + 1)
) (
  input  logic clk,
  input  logic rst_n,
  nw_vc_free_pool_if.slave bus
);
  generate
    if (nv < 2 || (nv & (nv - 1)) != 0) begin : g_bad_nv
      $error("nw_vc_free_pool: nv must be a power of two >= 2");
    end
    for (genvar p = 0; p < np; p++) begin : g_port
      nw_vc_free_pool_port #(.nv(nv), .cw(cw)) u_port (
        .clk          (clk),
        .rst_n        (rst_n),
        .vc_freed     (bus.vc_freed[p]),
        .pop          (bus.pop_free_vc[p]),
        .next_free_vc (bus.next_free_vc[p]),
        .no_free_vc   (bus.no_free_vc[p]),
        .status       (bus.vc_alloc_status[p]),
        .count        (bus.free_count[p]),
        .err          (bus.pool_error[p])
      );
    end
  endgenerate
endmodule

// File: tb/tb_nw_vc_free_pool.sv
// Directed bench for nw_vc_free_pool (np=5, nv=4) with hand-computed expectations.
module tb_nw_vc_free_pool;
  localparam int np = 5;
  localparam int nv = 4;
  localparam int cw = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  nw_vc_free_pool_if #(.np(np), .nv(nv), .cw(cw)) bus ();
  nw_vc_free_pool #(.np(np), .nv(nv), .cw(cw)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] fv(input int p, input logic [3:0] v);
    return 20'(v) << (4 * p);
  endfunction

  // Drive one cycle of stimulus (called just after a negedge), then idle inputs.
  task automatic op(input logic [19:0] fr, input logic [4:0] pp);
    bus.vc_freed    = fr;
    bus.pop_free_vc = pp;
    @(posedge clk);
    @(negedge clk);
    bus.vc_freed    = '0;
    bus.pop_free_vc = '0;
  endtask

  task automatic chk_reset_all(input string tag);
    chk({tag, "_next"},   32'(bus.next_free_vc),    32'h11111);
    chk({tag, "_empty"},  32'(bus.no_free_vc),      32'h0);
    chk({tag, "_status"}, 32'(bus.vc_alloc_status), 32'hfffff);
    chk({tag, "_count"},  32'(bus.free_count),      32'h4924); // five 3'd4 fields
    chk({tag, "_err"},    32'(bus.pool_error),      32'h0);
  endtask

  initial begin
    bus.vc_freed    = '0;
    bus.pop_free_vc = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_all("reset");

    // Drain port 2.
    chk("drain_h0", 32'(bus.next_free_vc[2]), 32'b0001);
    op('0, 5'b00100);
    chk("drain_h1", 32'(bus.next_free_vc[2]), 32'b0010);
    op('0, 5'b00100);
    chk("drain_h2", 32'(bus.next_free_vc[2]), 32'b0100);
    op('0, 5'b00100);
    chk("drain_h3", 32'(bus.next_free_vc[2]), 32'b1000);
    op('0, 5'b00100);
    chk("drain_empty",  32'(bus.no_free_vc[2]),      32'h1);
    chk("drain_next",   32'(bus.next_free_vc[2]),    32'h0);
    chk("drain_count",  32'(bus.free_count[2]),      32'h0);
    chk("drain_status", 32'(bus.vc_alloc_status[2]), 32'h0);
    chk("drain_other",  32'(bus.next_free_vc[0]),    32'b0001);
    chk("drain_ocnt",   32'(bus.free_count[3]),      32'h4);

    // Refill port 2 with VC2 then VC0; no bypass in the push cycle.
    bus.vc_freed = fv(2, 4'b0100);
    #1 chk("nobypass", 32'(bus.no_free_vc[2]), 32'h1);
    @(posedge clk); @(negedge clk);
    bus.vc_freed = '0;
    chk("refill_h1", 32'(bus.next_free_vc[2]), 32'b0100);
    chk("refill_c1", 32'(bus.free_count[2]),   32'h1);
    op(fv(2, 4'b0001), '0);
    chk("refill_h2", 32'(bus.next_free_vc[2]),    32'b0100);
    chk("refill_c2", 32'(bus.free_count[2]),      32'h2);
    chk("refill_s2", 32'(bus.vc_alloc_status[2]), 32'b0101);
    op('0, 5'b00100);
    chk("refill_h3", 32'(bus.next_free_vc[2]), 32'b0001);
    chk("refill_c3", 32'(bus.free_count[2]),   32'h1);

    // Pop and re-free the same VC: legal, re-enqueued.
    op(fv(2, 4'b0001), 5'b00100);
    chk("same_h",   32'(bus.next_free_vc[2]),    32'b0001);
    chk("same_c",   32'(bus.free_count[2]),      32'h1);
    chk("same_s",   32'(bus.vc_alloc_status[2]), 32'b0001);
    chk("same_err", 32'(bus.pool_error[2]),      32'h0);

    // Port 0: bring to count 2 (heads VC2, VC3), then pop + free VC0.
    op('0, 5'b00001);
    op('0, 5'b00001);
    chk("sim_pre_h", 32'(bus.next_free_vc[0]), 32'b0100);
    chk("sim_pre_c", 32'(bus.free_count[0]),   32'h2);
    op(fv(0, 4'b0001), 5'b00001);
    chk("sim_c",   32'(bus.free_count[0]),      32'h2);
    chk("sim_h",   32'(bus.next_free_vc[0]),    32'b1000);
    chk("sim_s",   32'(bus.vc_alloc_status[0]), 32'b1001);
    op('0, 5'b00001);
    chk("sim_h2",  32'(bus.next_free_vc[0]),    32'b0001);
    chk("sim_c2",  32'(bus.free_count[0]),      32'h1);
    chk("sim_err", 32'(bus.pool_error[0]),      32'h0);

    // Errors: pop empty port 1.
    repeat (4) op('0, 5'b00010);
    chk("pe_pre", 32'(bus.pool_error[1]), 32'h0);
    op('0, 5'b00010);
    chk("pe_err", 32'(bus.pool_error[1]), 32'h1);
    chk("pe_cnt", 32'(bus.free_count[1]), 32'h0);
    // Duplicate free on port 3.
    op(fv(3, 4'b0010), '0);
    chk("dup_err", 32'(bus.pool_error[3]), 32'h1);
    chk("dup_cnt", 32'(bus.free_count[3]), 32'h4);
    // Multi-bit free on port 4 after one pop (room exists, still rejected).
    op('0, 5'b10000);
    op(fv(4, 4'b0011), '0);
    chk("multi_err", 32'(bus.pool_error[4]),      32'h1);
    chk("multi_cnt", 32'(bus.free_count[4]),      32'h3);
    chk("multi_s",   32'(bus.vc_alloc_status[4]), 32'b1110);
    op('0, '0);
    chk("sticky",    32'(bus.pool_error),         32'b11010);

    // Async reset mid-cycle with port 0 half-drained.
    #2 rst_n = 1'b0;
    #1 chk_reset_all("areset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_all("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nw_vc_free_pool.md
Name: nw_vc_free_pool

Overview:
- Per-output-port free-VC pool that feeds the VC allocator in its restricted ("fifo_free_pool") mode.
- Each output port holds a FIFO of one-hot VC ids that are free at the downstream router. The allocator sees the head id as next_free_vc and the empty flag as no_free_vc, and consumes the head with pop_free_vc.
- VCs re-enter the pool when the downstream router returns the tail-flit credit (vc_freed).
- Also exports a free bitmap (vc_alloc_status) for the unrestricted allocator.

Parameters:
- np, 5, number of router ports (one pool per port).
- nv, 4, VCs per port; FIFO depth per port = nv.
- cw, clogb2(nv+1), width of per-port occupancy count.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- vc_freed  input  np*nv  [p][v]: VC v of output port p became free this cycle (tail credit returned). At most one bit set per port per cycle.
- pop_free_vc  input  np  [p]: allocator consumed the head VC of port p this cycle.
- next_free_vc  output  np*nv  [p]: one-hot head id of port p's FIFO; all-zero when empty.
- no_free_vc  output  np  [p]: port p FIFO empty.
- vc_alloc_status  output  np*nv  [p][v]=1 while VC v of port p is in the pool.
- free_count  output  np*cw  [p]: current FIFO occupancy, 0..nv.
- pool_error  output  np  [p]: sticky protocol-violation flag.

Behaviour:
- Ports are fully independent; everything below is per port p.
- Storage: nv entries of log2(nv)-bit VC index, read pointer, write pointer, count; next_free_vc is decoded to one-hot.
- Reset (asynchronous, rst_n=0), all ports:
  - FIFO preloaded full in order VC0,VC1,...,VC(nv-1); rd_ptr=0; wr_ptr=0 (wrapped); count=nv.
  - vc_alloc_status=all ones; next_free_vc=one-hot VC0 (4'b0001 for nv=4); no_free_vc=0; free_count=nv; pool_error=0.
- Reset mid-operation discards all in-flight state and returns to the reset contents above immediately.
- Outputs are registered-state driven only, with no combinational path from inputs:
  - next_free_vc and no_free_vc reflect the FIFO after the previous clock edge.
  - A VC pushed in cycle t is visible at the head no earlier than cycle t+1.
- Pop (pop_free_vc=1, count>0):
  - rd_ptr advances modulo nv; count decrements.
  - Head's vc_alloc_status bit clears at the edge.
- Push (one-hot vc_freed, count<nv, bit not already in vc_alloc_status):
  - Index written at wr_ptr; wr_ptr advances modulo nv; count increments.
  - vc_alloc_status bit sets at the edge.
- Simultaneous push and pop, count>0: both performed; count unchanged; FIFO order preserved (pushed VC goes to tail).
- Push and pop with count==0: pop illegal (see errors); push performed; count becomes 1. No bypass: no_free_vc stays 1 this cycle.
- Push of the same VC that is being popped this cycle: legal. The pop clears the bit, the push re-sets it, and the VC is enqueued at the tail.
- Error conditions. Each sets pool_error[p] (sticky until reset) and ignores the offending operation; the non-offending operation still completes.
  - Pop while empty.
  - vc_freed with more than one bit set for a port (whole push ignored).
  - Push of a VC already free, i.e. vc_alloc_status set and not being popped this cycle.
  - Push when count==nv with no simultaneous pop. This is unreachable if the duplicate check holds; it is still checked.
- Pointer wrap: pointers are log2(nv) bits. nv must be a power of two ≥2; an elaboration check fails otherwise.
- Invariant: free_count equals popcount(vc_alloc_status) on every cycle.

Test Plan:
- Reset: release rst_n with np=5, nv=4 → every port has next_free_vc=4'b0001, no_free_vc=0, free_count=4, vc_alloc_status=4'b1111, pool_error=0.
- Drain: pop port 2 on four consecutive cycles → heads seen are 0001, 0010, 0100, 1000. Then no_free_vc[2]=1, next_free_vc[2]=0000, free_count[2]=0, status 0000. Other ports unchanged.
- Refill order/wrap: from the drained port 2, free VC2 then VC0 on successive cycles → head becomes 0100 one cycle after the first push. A pop then yields 0001 as next head. rd/wr pointers wrap correctly, count=1.
- Simultaneous push/pop: port 0 with count=2 (heads VC2, VC3), pop plus free VC0 in the same cycle → count stays 2, head becomes 1000, then 0001; status=4'b1001.
- Errors: pop empty port 1 → pool_error[1]=1 and count stays 0. Free VC1 on port 3 while already free → pool_error[3]=1, count unchanged. vc_freed[4]=4'b0011 → pool_error[4]=1, push ignored.
- Async reset mid-operation: assert rst_n=0 between edges while port 0 is half-drained → outputs return to reset values without waiting for clk; pool_error cleared.
